riscv_test_monitor: RTL and testbench

Synthesizable, parametrised pass/fail monitor for the RISC-V core's ISA compliance runs. It snoops the register-file writeback port and keeps shadow copies of the two completion registers and the test-number register. After a settle window it produces a sticky verdict: pass, fail or watchdog timeout. It sits beside the core in `risc_v_cpu`, so the same verdict is available in simulation benches and on FPGA status pins.

---
 rtl/riscv_test_pkg.sv | 22 ++
 rtl/riscv_test_monitor_if.sv | 22 ++
 rtl/riscv_test_shadow.sv | 54 +++++
 rtl/riscv_test_monitor.sv | 189 ++++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_test_pkg.sv
// -----------------------------------------------------------------------------
// riscv_test_pkg
// Shared definitions for the ISA-compliance pass/fail monitor:
//   - mon_state_e : monitor FSM states (RUN / SETTLE / DONE)
//   - DEF_*       : default completion/test-number register indices and the
//                   default settle-window and watchdog lengths
// -----------------------------------------------------------------------------
package riscv_test_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } mon_state_e;

  localparam int DEF_DONE_REG_A     = 26;
  localparam int DEF_DONE_REG_B     = 27;
  localparam int DEF_TESTNUM_REG    = 3;
  localparam int DEF_SETTLE_CYCLES  = 10;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/riscv_test_monitor_if.sv
// -----------------------------------------------------------------------------
// riscv_test_monitor_if
// Register-file writeback port as seen by the test monitor.
//   wb_en   : register-file write enable
//   wb_addr : destination register index
//   wb_data : write data
// master : the core (drives the writeback)
// slave  : the monitor (snoops the writeback)
// -----------------------------------------------------------------------------
interface riscv_test_monitor_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;

  modport master (output wb_en, output wb_addr, output wb_data);
  modport slave  (input  wb_en, input  wb_addr, input  wb_data);

endinterface

// File: rtl/riscv_test_shadow.sv
// -----------------------------------------------------------------------------
// riscv_test_shadow
// Shadow copy of one architectural register, loaded from the writeback port.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : synchronous zeroing (wins over a load)
//   freeze_i   : hold current value, ignore writes
//   wb_en_i    : writeback enable
//   wb_addr_i  : writeback index; loads when equal to IDX (x0 never loads)
//   wb_data_i  : writeback data
//   sh_d_o     : value the shadow takes at the coming edge
//   sh_q_o     : current registered value
// -----------------------------------------------------------------------------
module riscv_test_shadow #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IDX        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  freeze_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic [XLEN-1:0]       sh_d_o,
  output logic [XLEN-1:0]       sh_q_o
);

  logic [XLEN-1:0] sh_q;
  logic [XLEN-1:0] sh_d;
  logic            hit;

  // x0 is hardwired to zero in the core, so a write to it is never shadowed
  assign hit = wb_en_i && (wb_addr_i == REG_ADDR_W'(IDX)) && (wb_addr_i != '0);

  always_comb begin
    sh_d = sh_q;
    if (clear_i)
      sh_d = '0;
    else if (hit && !freeze_i)
      sh_d = wb_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sh_q <= '0;
    else
      sh_q <= sh_d;
  end

  assign sh_d_o = sh_d;
  assign sh_q_o = sh_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// -----------------------------------------------------------------------------
// riscv_test_monitor
// Pass/fail monitor for ISA compliance runs. Snoops the register-file
// writeback, shadows the two completion registers and the test-number
// register, and after a settle window latches a sticky verdict.
//   clk, rst   : core clock, asynchronous active-high reset
//   clear      : synchronous restart (everything back to zero / RUN)
//   wb         : writeback port (slave modport)
//   done       : verdict valid, sticky
//   pass       : both completion registers equal 1 at the verdict
//   fail       : verdict by trigger, not pass
//   timeout    : watchdog expired before any trigger
//   test_num   : test-number shadow captured on verdict entry
//   cycle_cnt  : cycles since rst/clear, saturating, frozen once done
// -----------------------------------------------------------------------------
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int DONE_REG_A     = DEF_DONE_REG_A,
  parameter int DONE_REG_B     = DEF_DONE_REG_B,
  parameter int TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  riscv_test_monitor_if.slave  wb,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [XLEN-1:0]      test_num,
  output logic [CNT_W-1:0]     cycle_cnt
);

  localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam bit             WD_EN       = (TIMEOUT_CYCLES != 0);
  // Count value one edge before expiry: the edge that would make the
  // counter read TIMEOUT_CYCLES is the expiry edge.
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             to_q, to_d;
  logic [XLEN-1:0]  tnum_q, tnum_d;

  logic [XLEN-1:0]  sh_a_q, sh_a_d;
  logic [XLEN-1:0]  sh_b_q, sh_b_d;
  logic [XLEN-1:0]  sh_t_d;
  // The test-number shadow is only ever read through its next value
  logic [XLEN-1:0]  unused_sh_t_q;

  logic             freeze;
  logic             trig;
  logic             wd_expire;
  logic             both_one;

  assign freeze = (state_q == ST_DONE);

  riscv_test_shadow #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .IDX(DONE_REG_A)) u_sh_a (
    .clk(clk), .rst(rst), .clear_i(clear), .freeze_i(freeze),
    .wb_en_i(wb.wb_en), .wb_addr_i(wb.wb_addr), .wb_data_i(wb.wb_data),
    .sh_d_o(sh_a_d), .sh_q_o(sh_a_q)
  );

  riscv_test_shadow #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .IDX(DONE_REG_B)) u_sh_b (
    .clk(clk), .rst(rst), .clear_i(clear), .freeze_i(freeze),
    .wb_en_i(wb.wb_en), .wb_addr_i(wb.wb_addr), .wb_data_i(wb.wb_data),
    .sh_d_o(sh_b_d), .sh_q_o(sh_b_q)
  );

  riscv_test_shadow #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .IDX(TESTNUM_REG)) u_sh_t (
    .clk(clk), .rst(rst), .clear_i(clear), .freeze_i(freeze),
    .wb_en_i(wb.wb_en), .wb_addr_i(wb.wb_addr), .wb_data_i(wb.wb_data),
    .sh_d_o(sh_t_d), .sh_q_o(unused_sh_t_q)
  );

  // Trigger looks at registered shadows; the verdict looks at the values
  // landing at the verdict edge so a last-moment write still counts.
  assign trig      = (sh_a_q == XLEN'(1)) || (sh_b_q == XLEN'(1));
  assign both_one  = (sh_a_d == XLEN'(1)) && (sh_b_d == XLEN'(1));
  assign wd_expire = WD_EN && (cnt_q == WD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic; a trigger beats a coinciding watchdog expiry
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (clear) begin
      state_d  = ST_RUN;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (trig) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end else if (wd_expire) begin
            state_d  = ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0)
            state_d = ST_DONE;
          else
            settle_d = settle_q - 1'b1;
        end
        ST_DONE: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Output logic: cycle counter and verdict captured on DONE entry
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    to_d   = to_q;
    tnum_d = tnum_q;
    cnt_d  = cnt_q;
    if (clear) begin
      done_d = 1'b0;
      pass_d = 1'b0;
      fail_d = 1'b0;
      to_d   = 1'b0;
      tnum_d = '0;
      cnt_d  = '0;
    end else begin
      if (state_q != ST_DONE && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      if (state_q != ST_DONE && state_d == ST_DONE) begin
        done_d = 1'b1;
        tnum_d = sh_t_d;
        if (state_q == ST_RUN) begin
          to_d = 1'b1;
        end else begin
          pass_d = both_one;
          fail_d = !both_one;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      to_q   <= 1'b0;
      tnum_q <= '0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      to_q   <= to_d;
      tnum_q <= tnum_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = to_q;
  assign test_num  = tnum_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

  localparam int SETTLE = 10;
  localparam int TO_A   = 50;
  localparam int MAXN   = 1100;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        done_a, pass_a, fail_a, to_a;
  logic [31:0] tn_a, cnt_a;
  logic        done_b, pass_b, fail_b, to_b;
  logic [31:0] tn_b, cnt_b;

  int tests = 0;
  int fails = 0;

  // Writeback schedule: entry k is presented for edge k after the clear edge
  logic        s_en   [1:MAXN];
  logic [4:0]  s_addr [1:MAXN];
  logic [31:0] s_data [1:MAXN];

  // Observations after edge k (k=0 is the clear edge)
  logic        oa_done [0:MAXN];
  logic [2:0]  oa_pft  [0:MAXN];
  logic [31:0] oa_tn   [0:MAXN];
  logic [31:0] oa_cnt  [0:MAXN];
  logic        ob_done [0:MAXN];
  logic [2:0]  ob_pft  [0:MAXN];
  logic [31:0] ob_tn   [0:MAXN];
  logic [31:0] ob_cnt  [0:MAXN];

  riscv_test_monitor_if #(.XLEN(32), .REG_ADDR_W(5)) bus_a ();
  riscv_test_monitor_if #(.XLEN(32), .REG_ADDR_W(5)) bus_b ();

  assign bus_a.wb_en   = wb_en;
  assign bus_a.wb_addr = wb_addr;
  assign bus_a.wb_data = wb_data;
  assign bus_b.wb_en   = wb_en;
  assign bus_b.wb_addr = wb_addr;
  assign bus_b.wb_data = wb_data;

  riscv_test_monitor #(
    .XLEN(32), .REG_ADDR_W(5), .DONE_REG_A(26), .DONE_REG_B(27), .TESTNUM_REG(3),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO_A), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .wb(bus_a),
    .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(to_a),
    .test_num(tn_a), .cycle_cnt(cnt_a)
  );

  riscv_test_monitor #(
    .XLEN(32), .REG_ADDR_W(5), .DONE_REG_A(26), .DONE_REG_B(27), .TESTNUM_REG(3),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(0), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .wb(bus_b),
    .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(to_b),
    .test_num(tn_b), .cycle_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  task automatic blank(input int n);
    for (int k = 1; k <= n; k++) begin
      s_en[k] = 1'b0; s_addr[k] = '0; s_data[k] = '0;
    end
  endtask

  task automatic put(input int k, input int a, input logic [31:0] d);
    s_en[k] = 1'b1; s_addr[k] = 5'(a); s_data[k] = d;
  endtask

  task automatic record(input int k);
    oa_done[k] = done_a; oa_pft[k] = {pass_a, fail_a, to_a}; oa_tn[k] = tn_a; oa_cnt[k] = cnt_a;
    ob_done[k] = done_b; ob_pft[k] = {pass_b, fail_b, to_b}; ob_tn[k] = tn_b; ob_cnt[k] = cnt_b;
  endtask

  task automatic run_seq(input int n);
    clear = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge clk); #1;
    clear = 1'b0;
    record(0);
    for (int k = 1; k <= n; k++) begin
      wb_en = s_en[k]; wb_addr = s_addr[k]; wb_data = s_data[k];
      @(posedge clk); #1;
      record(k);
    end
    wb_en = 1'b0;
  endtask

  function automatic int first_done(input bit which, input int n);
    for (int k = 0; k <= n; k++)
      if ((which ? ob_done[k] : oa_done[k]) === 1'b1) return k;
    return -1;
  endfunction

  // Value a register holds after edge k: last shadowable write up to k
  function automatic logic [31:0] shadow_at(input int idx, input int k);
    logic [31:0] v;
    v = '0;
    for (int j = 1; j <= k; j++)
      if (s_en[j] && int'(s_addr[j]) == idx && idx != 0) v = s_data[j];
    return v;
  endfunction

  // Reference verdict for the current schedule: edge v of the verdict (-1 none)
  task automatic ref_verdict(input int n, input int to_lim, output int v,
                             output bit ep, output bit ef, output bit et,
                             output logic [31:0] etn);
    int e0;
    e0 = -1;
    for (int k = 1; k <= n && e0 < 0; k++)
      if (shadow_at(26, k) == 32'd1 || shadow_at(27, k) == 32'd1) e0 = k;
    v = -1; ep = 1'b0; ef = 1'b0; et = 1'b0; etn = '0;
    // Trigger is seen one edge after the write; it wins a tie with expiry
    if (e0 >= 0 && (to_lim == 0 || e0 + 1 <= to_lim)) begin
      v  = e0 + 1 + SETTLE;
      ep = (shadow_at(26, v) == 32'd1) && (shadow_at(27, v) == 32'd1);
      ef = !ep;
    end else if (to_lim != 0) begin
      v  = to_lim;
      et = 1'b1;
    end
    if (v > n) begin
      v = -1; ep = 1'b0; ef = 1'b0; et = 1'b0;
    end
    if (v >= 0) etn = shadow_at(3, v);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    tests++; if ({done_a, pass_a, fail_a, to_a} !== 4'b0) begin fails++;
      $display("FAIL reset_flags_a: got %b, required 0000", {done_a, pass_a, fail_a, to_a}); end
    tests++; if (tn_a !== 32'd0 || cnt_a !== 32'd0) begin fails++;
      $display("FAIL reset_values_a: test_num=%0d cycle_cnt=%0d, required 0/0", tn_a, cnt_a); end
    tests++; if ({done_b, pass_b, fail_b, to_b, tn_b, cnt_b} !== 68'd0) begin fails++;
      $display("FAIL reset_all_b: flags=%b tn=%0d cnt=%0d, required zeros", {done_b, pass_b, fail_b, to_b}, tn_b, cnt_b); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (cnt_a !== 32'd1) begin fails++;
      $display("FAIL reset_first_count: cycle_cnt=%0d, required 1", cnt_a); end
  endtask

  task automatic test_pass();
    int fd;
    blank(20); put(1, 3, 5); put(2, 26, 1); put(3, 27, 1);
    run_seq(20);
    fd = first_done(0, 20);
    tests++; if (fd != 13) begin fails++;
      $display("FAIL pass_latency: done rose at edge %0d, required 13", fd); end
    tests++; if (oa_pft[13] !== 3'b100) begin fails++;
      $display("FAIL pass_verdict: pass/fail/timeout=%b, required 100", oa_pft[13]); end
    tests++; if (oa_tn[13] !== 32'd5) begin fails++;
      $display("FAIL pass_test_num: got %0d, required 5", oa_tn[13]); end
    tests++; if (oa_cnt[20] !== 32'd13) begin fails++;
      $display("FAIL pass_cnt_frozen: got %0d, required 13", oa_cnt[20]); end
    tests++; if (oa_done[20] !== 1'b1 || oa_pft[20] !== 3'b100) begin fails++;
      $display("FAIL pass_sticky: done=%b pft=%b, required 1/100", oa_done[20], oa_pft[20]); end
    fd = first_done(1, 20);
    tests++; if (fd != 13 || ob_pft[20] !== 3'b100) begin fails++;
      $display("FAIL pass_no_watchdog: edge %0d pft=%b, required 13/100", fd, ob_pft[20]); end
  endtask

  task automatic test_fail();
    int fd;
    blank(18); put(1, 3, 7); put(2, 27, 1);
    run_seq(18);
    fd = first_done(0, 18);
    tests++; if (fd != 13) begin fails++;
      $display("FAIL fail_latency: done rose at edge %0d, required 13", fd); end
    tests++; if (oa_pft[18] !== 3'b010) begin fails++;
      $display("FAIL fail_verdict: pass/fail/timeout=%b, required 010", oa_pft[18]); end
    tests++; if (oa_tn[18] !== 32'd7) begin fails++;
      $display("FAIL fail_test_num: got %0d, required 7", oa_tn[18]); end
  endtask

  task automatic test_settle_window();
    int         offs [3] = '{9, 12, 13};
    logic [2:0] expv [3] = '{3'b100, 3'b100, 3'b010};
    int fd;
    for (int i = 0; i < 3; i++) begin
      blank(20); put(1, 26, 1); put(offs[i], 27, 1);
      run_seq(20);
      fd = first_done(0, 20);
      tests++; if (fd != 12) begin fails++;
        $display("FAIL settle_latency_%0d: done at edge %0d, required 12", offs[i], fd); end
      tests++; if (oa_pft[20] !== expv[i]) begin fails++;
        $display("FAIL settle_late_write_%0d: pft=%b, required %b", offs[i], oa_pft[20], expv[i]); end
    end
  endtask

  task automatic test_timeout();
    int fd;
    blank(60);
    run_seq(60);
    fd = first_done(0, 60);
    tests++; if (fd != 50) begin fails++;
      $display("FAIL timeout_edge: done at edge %0d, required 50", fd); end
    tests++; if (oa_pft[50] !== 3'b001 || oa_cnt[50] !== 32'd50) begin fails++;
      $display("FAIL timeout_verdict: pft=%b cnt=%0d, required 001/50", oa_pft[50], oa_cnt[50]); end
    tests++; if (oa_cnt[60] !== 32'd50 || oa_done[60] !== 1'b1) begin fails++;
      $display("FAIL timeout_frozen: cnt=%0d done=%b, required 50/1", oa_cnt[60], oa_done[60]); end

    blank(60); put(49, 3, 9);
    run_seq(60);
    tests++; if (oa_pft[50] !== 3'b001 || oa_tn[50] !== 32'd9) begin fails++;
      $display("FAIL timeout_test_num: pft=%b tn=%0d, required 001/9", oa_pft[50], oa_tn[50]); end

    // Trigger seen at the expiry edge wins
    blank(70); put(49, 26, 1);
    run_seq(70);
    fd = first_done(0, 70);
    tests++; if (fd != 60 || oa_pft[70] !== 3'b010 || oa_cnt[70] !== 32'd60) begin fails++;
      $display("FAIL timeout_tie: edge %0d pft=%b cnt=%0d, required 60/010/60", fd, oa_pft[70], oa_cnt[70]); end

    blank(70); put(50, 26, 1);
    run_seq(70);
    fd = first_done(0, 70);
    tests++; if (fd != 50 || oa_pft[70] !== 3'b001) begin fails++;
      $display("FAIL timeout_late_trigger: edge %0d pft=%b, required 50/001", fd, oa_pft[70]); end

    blank(1000);
    run_seq(1000);
    fd = first_done(1, 1000);
    tests++; if (fd != -1 || ob_cnt[1000] !== 32'd1000) begin fails++;
      $display("FAIL watchdog_disabled: done at edge %0d cnt=%0d, required none/1000", fd, ob_cnt[1000]); end
  endtask

  task automatic test_nontrigger();
    int fd;
    blank(30);
    s_en[1] = 1'b0; s_addr[1] = 5'd26; s_data[1] = 32'd1;
    put(2, 0, 1); put(3, 26, 2); put(4, 27, 3);
    run_seq(30);
    fd = first_done(0, 30);
    tests++; if (fd != -1 || oa_cnt[30] !== 32'd30) begin fails++;
      $display("FAIL no_trigger: done at edge %0d cnt=%0d, required none/30", fd, oa_cnt[30]); end

    blank(15); put(1, 26, 1); put(2, 27, 1);
    run_seq(15);
    tests++; if (oa_done[15] !== 1'b1) begin fails++;
      $display("FAIL clear_precondition: done=%b, required 1", oa_done[15]); end
    // Clear beats a trigger write at the same edge
    clear = 1'b1; wb_en = 1'b1; wb_addr = 5'd26; wb_data = 32'd1;
    @(posedge clk); #1;
    tests++; if ({done_a, pass_a, fail_a, to_a} !== 4'b0 || tn_a !== 32'd0 || cnt_a !== 32'd0) begin fails++;
      $display("FAIL clear_outputs: flags=%b tn=%0d cnt=%0d, required zeros", {done_a, pass_a, fail_a, to_a}, tn_a, cnt_a); end
    clear = 1'b0; wb_en = 1'b0;
    @(posedge clk); #1;
    tests++; if (cnt_a !== 32'd1) begin fails++;
      $display("FAIL clear_first_count: cnt=%0d, required 1", cnt_a); end
    repeat (15) begin @(posedge clk); #1; end
    tests++; if (done_a !== 1'b0 || cnt_a !== 32'd16) begin fails++;
      $display("FAIL clear_beats_write: done=%b cnt=%0d, required 0/16", done_a, cnt_a); end
  endtask

  task automatic test_async_rst();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd26; wb_data = 32'd1;
    @(posedge clk); #1;
    wb_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (cnt_a !== 32'd4 || done_a !== 1'b0) begin fails++;
      $display("FAIL rst_precondition: cnt=%0d done=%b, required 4/0", cnt_a, done_a); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({done_a, pass_a, fail_a} !== 3'b0 || cnt_a !== 32'd0 || cnt_b !== 32'd0) begin fails++;
      $display("FAIL rst_mid_settle: flags=%b cnt_a=%0d cnt_b=%0d, required zeros", {done_a, pass_a, fail_a}, cnt_a, cnt_b); end
    #1 rst = 1'b0;

    blank(15); put(1, 3, 4); put(1, 26, 1); put(2, 27, 1);
    put(1, 26, 1);
    run_seq(15);
    tests++; if (first_done(0, 15) != 12 || oa_pft[15] !== 3'b100) begin fails++;
      $display("FAIL rst_then_pass: edge %0d pft=%b, required 12/100", first_done(0, 15), oa_pft[15]); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({done_a, pass_a, fail_a, to_a} !== 4'b0 || cnt_a !== 32'd0) begin fails++;
      $display("FAIL rst_in_done: flags=%b cnt=%0d, required zeros", {done_a, pass_a, fail_a, to_a}, cnt_a); end
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    int v, fd, n;
    bit ep, ef, et;
    logic [31:0] etn, ecnt;
    n = 70;
    for (int t = 0; t < 40; t++) begin
      for (int k = 1; k <= n; k++) begin
        s_en[k] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0:       s_addr[k] = 5'd0;
          1:       s_addr[k] = 5'd3;
          2:       s_addr[k] = 5'd26;
          3:       s_addr[k] = 5'd27;
          default: s_addr[k] = 5'($urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 3))
          0:       s_data[k] = 32'd0;
          1:       s_data[k] = 32'd1;
          2:       s_data[k] = 32'd2;
          default: s_data[k] = $urandom;
        endcase
      end
      run_seq(n);

      ref_verdict(n, TO_A, v, ep, ef, et, etn);
      ecnt = (v >= 0) ? 32'(v) : 32'(n);
      fd = first_done(0, n);
      tests++; if (fd != v) begin fails++;
        $display("FAIL rand%0d_edge_a: done at %0d, required %0d", t, fd, v); end
      tests++; if ({oa_done[n], oa_pft[n]} !== {(v >= 0), ep, ef, et}) begin fails++;
        $display("FAIL rand%0d_flags_a: %b, required %b", t, {oa_done[n], oa_pft[n]}, {(v >= 0), ep, ef, et}); end
      tests++; if (oa_tn[n] !== etn || oa_cnt[n] !== ecnt) begin fails++;
        $display("FAIL rand%0d_vals_a: tn=%h cnt=%0d, required %h/%0d", t, oa_tn[n], oa_cnt[n], etn, ecnt); end

      ref_verdict(n, 0, v, ep, ef, et, etn);
      ecnt = (v >= 0) ? 32'(v) : 32'(n);
      fd = first_done(1, n);
      tests++; if (fd != v || {ob_done[n], ob_pft[n]} !== {(v >= 0), ep, ef, et}) begin fails++;
        $display("FAIL rand%0d_verdict_b: edge %0d flags=%b, required %0d/%b", t, fd, {ob_done[n], ob_pft[n]}, v, {(v >= 0), ep, ef, et}); end
      tests++; if (ob_tn[n] !== etn || ob_cnt[n] !== ecnt) begin fails++;
        $display("FAIL rand%0d_vals_b: tn=%h cnt=%0d, required %h/%0d", t, ob_tn[n], ob_cnt[n], etn, ecnt); end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_settle_window();
    test_timeout();
    test_nontrigger();
    test_async_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
